seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Time-multiplexing scan controller that shares one seven-segment decoder among NUM_DIGITS common-anode digits. Each cycle it presents one digit's 4-bit code to the shared decoder and enables that digit's anode. Between digits it inserts a dead-time gap with all anodes off to prevent ghosting. New display contents are loaded through a ready/valid handshake and applied only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 2..8
- DRIVE_CYCLES, 50000: clock cycles each digit is driven, ≥1
- DEAD_CYCLES, 2: clock cycles of all-off gap before each digit, ≥1
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- scan_en  input  1  1 = scan runs; 0 = all anodes off, scan restarts at digit 0
- load_valid  input  1  new frame data offered
- load_ready  output  1  controller can accept load_data
- load_data  input  4*NUM_DIGITS  digit codes; digit i = bits [4i+3:4i]
- load_blank  input  NUM_DIGITS  1 = digit i kept dark; captured with load_data
- code  output  4  code to shared decoder (x3..x0 = code[3:0])
- digit_en_n  output  NUM_DIGITS  active-low anode enables, at most one low
- frame_start  output  1  one-cycle pulse on entry to digit 0 DRIVE

## Operation
- Registers: shown[] (codes + blank), pending[], pend_flag, digit_idx, phase counter.
- FSM states: OFF, GAP, DRIVE.
  - OFF: entered on reset or when scan_en=0; all anodes off. If scan_en=1, go to GAP with digit_idx=0.
  - GAP: lasts DEAD_CYCLES cycles. All anodes off; code = shown code of digit_idx. Then go to DRIVE.
  - DRIVE: lasts DRIVE_CYCLES cycles. digit_en_n[digit_idx]=0 unless that digit is blanked; code unchanged. Then digit_idx increments modulo NUM_DIGITS and the FSM goes to GAP.
- scan_en=0 in any state → OFF on the next edge; the current digit is abandoned.
- Handshake: the transfer occurs when load_valid & load_ready at a rising edge. The transfer captures data into pending, sets pend_flag, and drops load_ready on the next cycle.
  - load_valid while load_ready=0 is ignored; no queuing.
- Apply: when the FSM leaves DRIVE of digit NUM_DIGITS-1, or moves OFF→GAP, and pend_flag=1:
  - shown ← pending;
  - pend_flag clears;
  - load_ready rises in the same edge.
- Simultaneous apply and load_valid: load_ready was 0 that cycle, so the load is not accepted.
- A load accepted while in OFF is applied on the OFF→GAP edge.
- Reset values: state OFF, digit_idx 0, code 4'h0, digit_en_n all ones, load_ready 1, frame_start 0, shown codes 0, shown blank all ones, pend_flag 0.
- Reset assertion mid-scan clears everything asynchronously; anodes turn off without waiting for a clock edge.

## Timing
- Frame period = NUM_DIGITS*(DEAD_CYCLES+DRIVE_CYCLES) cycles.
- code is stable ≥DEAD_CYCLES cycles before its anode enables.
- code holds for the whole DRIVE slot.
- All outputs are registered; no combinational path from inputs to outputs.
- Load → visible latency: at most one frame + DEAD_CYCLES.
- frame_start is high for the first DRIVE cycle of digit 0 only. It pulses even when digit 0 is blanked.

## Structure
- Shared package seven_seg_pkg:
  - localparam CODE_W = 4;
  - state enum {ST_OFF, ST_GAP, ST_DRIVE};
  - function onehot_n(idx) returning the active-low anode vector.
- One sub-module, scan_phase_cnt: a loadable down-counter whose width covers max(DRIVE_CYCLES, DEAD_CYCLES). It reloads on each state entry and signals terminal count.
- The shared seven-segment decoder sits outside this block, driven by code.

## Test plan
Test parameters: NUM_DIGITS=4, DRIVE_CYCLES=4, DEAD_CYCLES=1.
- Reset then scan_en=1 with no load → digit_en_n stays 4'b1111 (all blanked); frame_start pulses every 20 cycles; load_ready=1.
- Load load_data=16'h4321, load_blank=0 → load_ready=0 until the next frame boundary. Afterwards per frame:
  - code sequence 1,2,3,4, each for 5 cycles;
  - digit_en_n sequence 1110, 1101, 1011, 0111, each low for 4 cycles preceded by 1 all-off cycle.
- Load 16'h8765 while digit 2 of the old frame is driving → digits 2 and 3 finish with 3 and 4; the new frame starts with 5. load_ready rises on that edge.
- load_valid held high, with a second load offered while load_ready=0 → the second value is never shown. The next handshake after load_ready rises is accepted.
- load_blank=4'b0100 → digit_en_n never equals 4'b1011; code still cycles through the digit 2 value.
- scan_en dropped mid-DRIVE of digit 1, and separately rst_n pulsed low between edges → anodes go 4'b1111 on the next edge (or immediately for reset). Restart resumes at digit 0 with frame_start.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Holds the FSM encoding and the active-low anode decoder.
package seven_seg_pkg;

   localparam int CODE_W     = 4;
   localparam int MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_GAP,
      ST_DRIVE
   } state_t;

   // All ones except a single zero at idx; callers truncate to their digit count.
   function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [2:0] idx);
      logic [MAX_DIGITS-1:0] v;
      v      = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/scan_phase_cnt.sv
// Loadable down-counter timing the GAP and DRIVE phases; o_tc is high while the count is zero.
// Load value N-1 gives a phase of N cycles; no backpressure.
module scan_phase_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode scan: GAP (all off) then DRIVE per digit; all outputs registered.
// New frames are accepted via valid/ready and applied only at a frame boundary; ready stays low meanwhile.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DRIVE_CYCLES = 50000,
   parameter int DEAD_CYCLES  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         scan_en,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]        load_blank,
   output logic [CODE_W-1:0]            code,
   output logic [NUM_DIGITS-1:0]        digit_en_n,
   output logic                         frame_start
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int MAX_CYC = (DRIVE_CYCLES > DEAD_CYCLES) ? DRIVE_CYCLES : DEAD_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LEN = CNT_W'(DRIVE_CYCLES - 1);

   state_t                               r_state;
   state_t                               w_state_nxt;
   logic [IDX_W-1:0]                     r_digit_idx;
   logic [IDX_W-1:0]                     w_idx_nxt;
   logic                                 w_gap_entry;
   logic                                 w_drive_entry;
   logic                                 w_apply;
   logic                                 w_accept;
   logic                                 w_tc;
   logic                                 w_cnt_load;
   logic [CNT_W-1:0]                     w_cnt_val;

   logic [NUM_DIGITS-1:0][CODE_W-1:0]    r_shown_code;
   logic [NUM_DIGITS-1:0][CODE_W-1:0]    r_pend_code;
   logic [NUM_DIGITS-1:0][CODE_W-1:0]    w_shown_code_nxt;
   logic [NUM_DIGITS-1:0]                r_shown_blank;
   logic [NUM_DIGITS-1:0]                r_pend_blank;
   logic [NUM_DIGITS-1:0]                w_shown_blank_nxt;
   logic                                 r_pend_flag;
   logic                                 r_load_ready;

   logic [CODE_W-1:0]                    r_code;
   logic [CODE_W-1:0]                    w_code_nxt;
   logic [NUM_DIGITS-1:0]                r_digit_en_n;
   logic [NUM_DIGITS-1:0]                w_en_n_nxt;
   logic                                 r_frame_start;
   logic                                 w_fs_nxt;

   // Phase timer reloads on every GAP or DRIVE entry.
   assign w_cnt_load = w_gap_entry | w_drive_entry;
   assign w_cnt_val  = w_drive_entry ? DRIVE_LEN : GAP_LEN;

   scan_phase_cnt #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .o_tc       (w_tc)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_OFF;
         r_digit_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_digit_idx <= w_idx_nxt;
      end
   end

   // FSM next state; w_apply marks a frame boundary with a pending frame waiting.
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_digit_idx;
      w_gap_entry   = 1'b0;
      w_drive_entry = 1'b0;
      w_apply       = 1'b0;
      if (!scan_en) begin
         w_state_nxt = ST_OFF;
         w_idx_nxt   = '0;
      end else begin
         unique case (r_state)
            ST_OFF: begin
               w_state_nxt = ST_GAP;
               w_idx_nxt   = '0;
               w_gap_entry = 1'b1;
               w_apply     = r_pend_flag;
            end
            ST_GAP: begin
               if (w_tc) begin
                  w_state_nxt   = ST_DRIVE;
                  w_drive_entry = 1'b1;
               end
            end
            ST_DRIVE: begin
               if (w_tc) begin
                  w_state_nxt = ST_GAP;
                  w_gap_entry = 1'b1;
                  if (r_digit_idx == LAST_IDX) begin
                     w_idx_nxt = '0;
                     w_apply   = r_pend_flag;
                  end else begin
                     w_idx_nxt = r_digit_idx + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_OFF;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // FSM outputs, computed from the upcoming state so they can be registered.
   always_comb begin
      w_shown_code_nxt  = w_apply ? r_pend_code  : r_shown_code;
      w_shown_blank_nxt = w_apply ? r_pend_blank : r_shown_blank;
      w_code_nxt        = w_shown_code_nxt[w_idx_nxt];
      w_en_n_nxt        = '1;
      if ((w_state_nxt == ST_DRIVE) && !w_shown_blank_nxt[w_idx_nxt]) begin
         w_en_n_nxt = NUM_DIGITS'(onehot_n(3'(w_idx_nxt)));
      end
      w_fs_nxt = w_drive_entry && (w_idx_nxt == '0);
   end

   // Accept and apply never coincide: apply needs pend_flag, accept needs ready.
   assign w_accept = load_valid & r_load_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shown_code  <= '0;
         r_shown_blank <= '1;
         r_pend_code   <= '0;
         r_pend_blank  <= '0;
         r_pend_flag   <= 1'b0;
         r_load_ready  <= 1'b1;
      end else if (w_accept) begin
         r_pend_code   <= load_data;
         r_pend_blank  <= load_blank;
         r_pend_flag   <= 1'b1;
         r_load_ready  <= 1'b0;
      end else if (w_apply) begin
         r_shown_code  <= r_pend_code;
         r_shown_blank <= r_pend_blank;
         r_pend_flag   <= 1'b0;
         r_load_ready  <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code        <= '0;
         r_digit_en_n  <= '1;
         r_frame_start <= 1'b0;
      end else begin
         r_code        <= w_code_nxt;
         r_digit_en_n  <= w_en_n_nxt;
         r_frame_start <= w_fs_nxt;
      end
   end

   assign load_ready  = r_load_ready;
   assign code        = r_code;
   assign digit_en_n  = r_digit_en_n;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with 4 digits, 4-cycle drive, 1-cycle dead time.
// A timeline model (position within the frame) predicts every output each cycle.
module tb_seven_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int DRV   = 4;
   localparam int DED   = 1;
   localparam int SLOT  = DED + DRV;
   localparam int FRAME = N * SLOT;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        scan_en    = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data  = 16'h0;
   logic [3:0]  load_blank = 4'h0;
   logic        load_ready;
   logic        frame_start;
   logic [3:0]  code;
   logic [3:0]  digit_en_n;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (N),
      .DRIVE_CYCLES (DRV),
      .DEAD_CYCLES  (DED)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_en     (scan_en),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .load_blank  (load_blank),
      .code        (code),
      .digit_en_n  (digit_en_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Model: m_t is the cycle position within the current frame (0 = GAP of digit 0).
   bit          m_on         = 1'b0;
   int          m_t          = 0;
   bit          m_ready      = 1'b1;
   logic [15:0] m_pend_code  = 16'h0;
   logic [3:0]  m_pend_blank = 4'h0;
   logic [15:0] m_shown_code = 16'h0;
   logic [3:0]  m_shown_blank = 4'hF;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_on          <= 1'b0;
         m_t           <= 0;
         m_ready       <= 1'b1;
         m_pend_code   <= 16'h0;
         m_pend_blank  <= 4'h0;
         m_shown_code  <= 16'h0;
         m_shown_blank <= 4'hF;
      end else begin
         if (!scan_en) begin
            m_on <= 1'b0;
         end else begin
            m_on <= 1'b1;
            m_t  <= m_on ? (m_t + 1) % FRAME : 0;
            if ((!m_on || m_t == FRAME - 1) && !m_ready) begin
               m_shown_code  <= m_pend_code;
               m_shown_blank <= m_pend_blank;
               m_ready       <= 1'b1;
            end
         end
         if (load_valid && m_ready) begin
            m_pend_code  <= load_data;
            m_pend_blank <= load_blank;
            m_ready      <= 1'b0;
         end
      end
   end

   int    checks = 0;
   int    errors = 0;
   string lit_name [128];
   int    lit_act  [128];
   int    lit_exp  [128];
   int    lit_n    = 0;
   int    lit_done = 0;

   initial begin : compare
      int         dig;
      int         pos;
      logic [3:0] ea;
      logic [3:0] ec;
      bit         ef;
      forever begin
         @(negedge clk);
         ea = 4'hF;
         ec = 4'h0;
         ef = 1'b0;
         if (m_on) begin
            dig = m_t / SLOT;
            pos = m_t % SLOT;
            if (pos >= DED && !m_shown_blank[dig]) ea = ~(4'b0001 << dig);
            ec = m_shown_code[dig*4 +: 4];
            ef = (m_t == DED);
         end
         checks++;
         if (digit_en_n !== ea) begin
            errors++;
            $display("FAIL anode @%0t got %b want %b", $time, digit_en_n, ea);
         end
         checks++;
         if (frame_start !== ef) begin
            errors++;
            $display("FAIL frame_start @%0t got %b want %b", $time, frame_start, ef);
         end
         checks++;
         if (load_ready !== m_ready) begin
            errors++;
            $display("FAIL load_ready @%0t got %b want %b", $time, load_ready, m_ready);
         end
         if (m_on) begin
            checks++;
            if (code !== ec) begin
               errors++;
               $display("FAIL code @%0t got %h want %h", $time, code, ec);
            end
         end
         while (lit_done < lit_n) begin
            checks++;
            if (lit_act[lit_done] != lit_exp[lit_done]) begin
               errors++;
               $display("FAIL %s got %0h want %0h", lit_name[lit_done],
                        lit_act[lit_done], lit_exp[lit_done]);
            end
            lit_done++;
         end
      end
   end

   task automatic lit(input string nm, input int act, input int e);
      if (lit_n < 128) begin
         lit_name[lit_n] = nm;
         lit_act[lit_n]  = act;
         lit_exp[lit_n]  = e;
         lit_n++;
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fs(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start && n < 100);
      lit(tag, int'(frame_start), 1);
   endtask

   initial begin : stim
      int n;
      bit saw;
      tick();
      tick();
      lit("rst_anode", int'(digit_en_n), 'hF);
      lit("rst_ready", int'(load_ready), 1);
      lit("rst_code", int'(code), 0);
      lit("rst_fs", int'(frame_start), 0);
      rst_n   = 1'b1;
      scan_en = 1'b1;

      // Idle scan: everything blanked, frame every 20 cycles.
      wait_fs("fs_first", n);
      wait_fs("fs_second", n);
      lit("fs_period", n, FRAME);
      lit("idle_anode", int'(digit_en_n), 'hF);
      lit("idle_ready", int'(load_ready), 1);

      // First load at t=1; shown from the next frame.
      load_valid = 1'b1;
      load_data  = 16'h4321;
      load_blank = 4'h0;
      tick();
      load_valid = 1'b0;
      lit("ready_drop", int'(load_ready), 0);
      wait_fs("fs_load1", n);
      lit("ready_rise", int'(load_ready), 1);
      lit("d0_anode", int'(digit_en_n), 'b1110);
      lit("d0_code", int'(code), 1);
      repeat (5) tick();
      lit("d1_anode", int'(digit_en_n), 'b1101);
      lit("d1_code", int'(code), 2);
      repeat (10) tick();
      lit("d3_anode", int'(digit_en_n), 'b0111);
      lit("d3_code", int'(code), 4);
      repeat (4) tick();
      lit("gap_anode", int'(digit_en_n), 'hF);
      lit("gap_code", int'(code), 1);

      // Load mid-frame at digit 2, then keep valid high with other data.
      repeat (11) tick();
      lit("d2_old_code", int'(code), 3);
      load_valid = 1'b1;
      load_data  = 16'h8765;
      tick();
      lit("ready_after_8765", int'(load_ready), 0);
      lit("d2_keeps_old", int'(code), 3);
      load_data = 16'hAAAA;
      repeat (4) tick();
      lit("d3_keeps_old", int'(code), 4);
      lit("ready_held_low", int'(load_ready), 0);
      repeat (4) tick();
      lit("apply_ready_rise", int'(load_ready), 1);
      lit("new_gap_code", int'(code), 5);
      load_data = 16'h6E0C;
      tick();
      lit("new_fs", int'(frame_start), 1);
      lit("new_d0_code", int'(code), 5);
      lit("new_d0_anode", int'(digit_en_n), 'b1110);
      lit("ready_after_6e0c", int'(load_ready), 0);
      load_valid = 1'b0;
      wait_fs("fs_6e0c", n);
      lit("c_d0_code", int'(code), 'hC);
      repeat (5) tick();
      lit("c_d1_code", int'(code), 'h0);
      repeat (5) tick();
      lit("c_d2_code", int'(code), 'hE);
      repeat (5) tick();
      lit("c_d3_code", int'(code), 'h6);

      // Blank digit 2.
      n = 0;
      while (!load_ready && n < 100) begin
         tick();
         n++;
      end
      lit("ready_for_blank", int'(load_ready), 1);
      load_valid = 1'b1;
      load_data  = 16'h1234;
      load_blank = 4'b0100;
      tick();
      load_valid = 1'b0;
      load_blank = 4'h0;
      wait_fs("fs_blank", n);
      lit("b_d0_code", int'(code), 4);
      lit("b_d0_anode", int'(digit_en_n), 'b1110);
      saw = 1'b0;
      for (int i = 1; i < FRAME; i++) begin
         tick();
         if (digit_en_n == 4'b1011) saw = 1'b1;
         if (i == 10) begin
            lit("blank_d2_anode", int'(digit_en_n), 'hF);
            lit("blank_d2_code", int'(code), 2);
         end
      end
      lit("never_1011", int'(saw), 0);

      // Drop scan_en during DRIVE of digit 1.
      wait_fs("fs_pre_stop", n);
      repeat (6) tick();
      lit("stop_d1_anode", int'(digit_en_n), 'b1101);
      lit("stop_d1_code", int'(code), 3);
      scan_en = 1'b0;
      tick();
      lit("stop_anode", int'(digit_en_n), 'hF);
      lit("stop_fs", int'(frame_start), 0);
      repeat (2) tick();
      scan_en = 1'b1;
      tick();
      lit("restart_gap_anode", int'(digit_en_n), 'hF);
      lit("restart_gap_fs", int'(frame_start), 0);
      tick();
      lit("restart_fs", int'(frame_start), 1);
      lit("restart_anode", int'(digit_en_n), 'b1110);
      lit("restart_code", int'(code), 4);

      // Asynchronous reset pulse between clock edges.
      repeat (7) tick();
      lit("pre_rst_anode", int'(digit_en_n), 'b1101);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      lit("async_rst_anode", int'(digit_en_n), 'hF);
      lit("async_rst_code", int'(code), 0);
      #1 rst_n = 1'b1;
      tick();
      lit("post_rst_off", int'(digit_en_n), 'hF);
      tick();
      tick();
      lit("post_rst_fs", int'(frame_start), 1);
      lit("post_rst_anode", int'(digit_en_n), 'hF);

      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
